regfile_wb_scheduler: RTL and testbench

- Sits between the pipeline and the register file's single write port (clock, we, addr, 32-bit data, combinational read-bypass of the word being written).
- Keeps a scoreboard of pending destination registers and stalls issue on RAW/WAW hazards.
- Merges two writeback sources onto that port:
  - ALU path: non-stallable, buffered in a FIFO.
  - Memory/multi-cycle path: valid/ready handshake.
- Round-robin arbitration, with pressure override when the FIFO is near full.

---
 rtl/regfile_wb_scheduler_if.sv | 36 +++
 rtl/regfile_wb_scheduler.sv | 113 +++++++++++
 tb/tb_regfile_wb_scheduler.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of issue, writeback and register-file commit signals for regfile_wb_scheduler.
// The scheduler connects through the slave modport; the pipeline side uses master.
interface regfile_wb_scheduler_if;
  logic        issue_valid;
  logic [4:0]  issue_rs;
  logic [4:0]  issue_rt;
  logic [4:0]  issue_dst;
  logic        issue_wr;
  logic        issue_stall;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_addr;
  logic [31:0] alu_wb_data;
  logic        mem_wb_valid;
  logic [4:0]  mem_wb_addr;
  logic [31:0] mem_wb_data;
  logic        mem_wb_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] busy;
  logic        overflow;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_dst, issue_wr,
    output alu_wb_valid, alu_wb_addr, alu_wb_data,
    output mem_wb_valid, mem_wb_addr, mem_wb_data,
    input  issue_stall, mem_wb_ready, rf_we, rf_addr, rf_data, busy, overflow
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_dst, issue_wr,
    input  alu_wb_valid, alu_wb_addr, alu_wb_data,
    input  mem_wb_valid, mem_wb_addr, mem_wb_data,
    output issue_stall, mem_wb_ready, rf_we, rf_addr, rf_data, busy, overflow
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: hazard scoreboard plus round-robin merge of a buffered ALU
// stream and a handshaked memory stream onto the single register-file write port.
module regfile_wb_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_SLACK  = 2
) (
  input logic                   clock,
  input logic                   reset,
  regfile_wb_scheduler_if.slave wb
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] PRESS_LVL = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] STALL_LVL = CNT_W'(FIFO_DEPTH - ALU_SLACK);

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  logic [4:0]       fifo_addr_q [FIFO_DEPTH];
  logic [31:0]      fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  src_e             last_q, last_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_addr_q, rf_addr_d;
  logic [31:0]      rf_data_q, rf_data_d;
  logic [31:0]      busy_q, busy_d;
  logic             overflow_q, overflow_d;
  logic             grant_alu, grant_mem, push, stall, accept;

  // A pending register stops being a hazard in the cycle its commit is on the port.
  function automatic logic hazard(input logic [31:0] pend, input logic we,
                                  input logic [4:0] waddr, input logic [4:0] r);
    return pend[r] && !(we && (waddr == r));
  endfunction

  always_comb begin
    grant_alu = (count_q != '0) &&
                (!wb.mem_wb_valid || (count_q >= PRESS_LVL) || (last_q == SRC_MEM));
    grant_mem = wb.mem_wb_valid && !grant_alu && !reset;
    stall     = reset ||
                hazard(busy_q, rf_we_q, rf_addr_q, wb.issue_rs) ||
                hazard(busy_q, rf_we_q, rf_addr_q, wb.issue_rt) ||
                (wb.issue_wr && hazard(busy_q, rf_we_q, rf_addr_q, wb.issue_dst)) ||
                (count_q > STALL_LVL);
    accept     = wb.issue_valid && !stall;
    push       = wb.alu_wb_valid && (count_q != FULL_LVL);
    overflow_d = overflow_q || (wb.alu_wb_valid && (count_q == FULL_LVL));
    count_d    = count_q + CNT_W'(push) - CNT_W'(grant_alu);

    busy_d = busy_q;
    if (rf_we_q) busy_d[rf_addr_q] = 1'b0;
    if (accept && wb.issue_wr) busy_d[wb.issue_dst] = 1'b1;
    busy_d[0] = 1'b0;

    last_d    = last_q;
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (grant_alu) begin
      last_d    = SRC_ALU;
      rf_addr_d = fifo_addr_q[rd_ptr_q];
      rf_data_d = fifo_data_q[rd_ptr_q];
      rf_we_d   = (fifo_addr_q[rd_ptr_q] != 5'd0);
    end else if (grant_mem) begin
      last_d    = SRC_MEM;
      rf_addr_d = wb.mem_wb_addr;
      rf_data_d = wb.mem_wb_data;
      rf_we_d   = (wb.mem_wb_addr != 5'd0);
    end
  end

  // Commit / control stage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= SRC_MEM;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= 5'd0;
      rf_data_q  <= 32'd0;
      busy_q     <= 32'd0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_q   <= grant_alu ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_q    <= count_d;
      last_q     <= last_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= wb.alu_wb_addr;
      fifo_data_q[wr_ptr_q] <= wb.alu_wb_data;
    end
  end

  assign wb.issue_stall  = stall;
  assign wb.mem_wb_ready = grant_mem;
  assign wb.rf_we        = rf_we_q;
  assign wb.rf_addr      = rf_addr_q;
  assign wb.rf_data      = rf_data_q;
  assign wb.busy         = busy_q;
  assign wb.overflow     = overflow_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios plus a randomized run, all
// checked against a queue-based reference model of the scheduling rules.
module tb_regfile_wb_scheduler;
  localparam int D = 4;
  localparam int S = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  regfile_wb_scheduler_if ifc ();
  regfile_wb_scheduler #(.FIFO_DEPTH(D), .ALU_SLACK(S)) dut (
    .clock(clock), .reset(reset), .wb(ifc));

  always #5 clock = ~clock;

  logic [31:0] m_busy;
  logic [4:0]  mq_addr[$];
  logic [31:0] mq_data[$];
  bit          m_last_mem;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_ovf;
  logic        exp_stall, exp_ready, obs_stall, obs_ready;
  bit          mem_acc;

  task automatic model_reset();
    m_busy = 32'd0; mq_addr.delete(); mq_data.delete();
    m_last_mem = 1'b1; m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_ovf = 1'b0;
    mem_acc = 1'b0;
  endtask

  task automatic idle_inputs();
    ifc.issue_valid = 0; ifc.issue_rs = 0; ifc.issue_rt = 0; ifc.issue_dst = 0; ifc.issue_wr = 0;
    ifc.alu_wb_valid = 0; ifc.alu_wb_addr = 0; ifc.alu_wb_data = 0;
    ifc.mem_wb_valid = 0; ifc.mem_wb_addr = 0; ifc.mem_wb_data = 0;
  endtask

  function automatic bit m_hz(input logic [4:0] r);
    return m_busy[r] && !(m_we && (m_addr == r));
  endfunction

  // One clock: predict combinational outputs, capture DUT's, then advance the model.
  task automatic step();
    int n;
    bit a, m, g_alu, g_mem;
    logic [31:0] nb;
    #1;
    n = mq_addr.size();
    exp_stall = m_hz(ifc.issue_rs) || m_hz(ifc.issue_rt) ||
                (ifc.issue_wr && m_hz(ifc.issue_dst)) || (n > D - S);
    a = (n > 0);
    m = ifc.mem_wb_valid;
    g_alu = a && (!m || (n >= D - 1) || m_last_mem);
    g_mem = m && !g_alu;
    exp_ready = g_mem;
    obs_stall = ifc.issue_stall;
    obs_ready = ifc.mem_wb_ready;
    @(posedge clock);
    nb = m_busy;
    if (m_we) nb[m_addr] = 1'b0;
    if (ifc.issue_valid && !exp_stall && ifc.issue_wr && ifc.issue_dst != 0) nb[ifc.issue_dst] = 1'b1;
    m_busy = nb;
    if (g_alu) begin
      m_addr = mq_addr.pop_front(); m_data = mq_data.pop_front();
      m_we = (m_addr != 0); m_last_mem = 1'b0;
    end else if (g_mem) begin
      m_addr = ifc.mem_wb_addr; m_data = ifc.mem_wb_data;
      m_we = (m_addr != 0); m_last_mem = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (ifc.alu_wb_valid) begin
      if (n == D) m_ovf = 1'b1;
      else begin mq_addr.push_back(ifc.alu_wb_addr); mq_data.push_back(ifc.alu_wb_data); end
    end
    mem_acc = g_mem;
    @(negedge clock);
  endtask

  // Let pending memory and ALU traffic finish with no new stimulus.
  task automatic settle();
    ifc.alu_wb_valid = 0; ifc.issue_valid = 0;
    for (int i = 0; i < 20; i++) begin
      if (!ifc.mem_wb_valid && mq_addr.size() == 0 && !m_we) break;
      step();
      if (mem_acc) ifc.mem_wb_valid = 0;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    model_reset();
    #1 reset = 1'b1;
    ifc.mem_wb_valid = 1; ifc.mem_wb_addr = 5'd4;
    @(negedge clock);
    checks++; if (ifc.busy !== 32'd0) begin failures++; $display("FAIL rst_busy got=%h exp=0", ifc.busy); end
    checks++; if (ifc.rf_we !== 1'b0) begin failures++; $display("FAIL rst_rf_we got=%b exp=0", ifc.rf_we); end
    checks++; if (ifc.rf_addr !== 5'd0 || ifc.rf_data !== 32'd0) begin failures++; $display("FAIL rst_rf got=%h/%h exp=0/0", ifc.rf_addr, ifc.rf_data); end
    checks++; if (ifc.overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", ifc.overflow); end
    checks++; if (ifc.issue_stall !== 1'b1) begin failures++; $display("FAIL rst_stall got=%b exp=1", ifc.issue_stall); end
    checks++; if (ifc.mem_wb_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", ifc.mem_wb_ready); end
    ifc.mem_wb_valid = 0;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_scoreboard();
    ifc.issue_valid = 1; ifc.issue_dst = 5; ifc.issue_wr = 1;
    step();
    checks++; if (obs_stall !== 1'b0) begin failures++; $display("FAIL sb_first_stall got=%b exp=0", obs_stall); end
    checks++; if (ifc.busy !== 32'h0000_0020) begin failures++; $display("FAIL sb_busy_set got=%h exp=00000020", ifc.busy); end
    ifc.issue_dst = 0; ifc.issue_wr = 0; ifc.issue_rs = 5;
    step();
    checks++; if (obs_stall !== 1'b1) begin failures++; $display("FAIL sb_raw_stall got=%b exp=1", obs_stall); end
    ifc.alu_wb_valid = 1; ifc.alu_wb_addr = 5; ifc.alu_wb_data = 32'hA5A5_0005;
    step();
    ifc.alu_wb_valid = 0;
    checks++; if (obs_stall !== 1'b1) begin failures++; $display("FAIL sb_stall_push got=%b exp=1", obs_stall); end
    step();
    checks++; if (obs_stall !== 1'b1) begin failures++; $display("FAIL sb_stall_pop got=%b exp=1", obs_stall); end
    checks++; if (ifc.rf_we !== 1'b1 || ifc.rf_addr !== 5'd5) begin failures++; $display("FAIL sb_commit got=%b/%0d exp=1/5", ifc.rf_we, ifc.rf_addr); end
    step();
    checks++; if (obs_stall !== 1'b0) begin failures++; $display("FAIL sb_bypass got=%b exp=0", obs_stall); end
    checks++; if (ifc.busy !== 32'd0) begin failures++; $display("FAIL sb_busy_clr got=%h exp=0", ifc.busy); end
    idle_inputs();
    step();
  endtask

  task automatic test_alu_latency();
    ifc.alu_wb_valid = 1; ifc.alu_wb_addr = 3; ifc.alu_wb_data = 32'hDEAD_BEEF;
    step();
    ifc.alu_wb_valid = 0;
    checks++; if (ifc.rf_we !== 1'b0) begin failures++; $display("FAIL lat_t1 got=%b exp=0", ifc.rf_we); end
    step();
    checks++; if (ifc.rf_we !== 1'b1 || ifc.rf_addr !== 5'd3 || ifc.rf_data !== 32'hDEAD_BEEF)
      begin failures++; $display("FAIL lat_t2 got=%b/%0d/%h exp=1/3/deadbeef", ifc.rf_we, ifc.rf_addr, ifc.rf_data); end
    step();
    checks++; if (ifc.rf_we !== 1'b0) begin failures++; $display("FAIL lat_t3 got=%b exp=0", ifc.rf_we); end
  endtask

  task automatic test_arbitration();
    logic exp_r;
    ifc.mem_wb_valid = 1; ifc.mem_wb_addr = 7; ifc.mem_wb_data = $urandom;
    for (int i = 0; i < 12; i++) begin
      ifc.alu_wb_valid = 1; ifc.alu_wb_addr = 9; ifc.alu_wb_data = $urandom;
      step();
      exp_r = (i < 6) ? ((i % 2) == 0) : 1'b0;
      checks++; if (obs_ready !== exp_r) begin failures++; $display("FAIL arb_ready[%0d] got=%b exp=%b", i, obs_ready, exp_r); end
      checks++; if (obs_stall !== (i >= 5)) begin failures++; $display("FAIL arb_stall[%0d] got=%b exp=%b", i, obs_stall, i >= 5); end
      checks++; if (ifc.rf_addr !== m_addr || ifc.rf_data !== m_data)
        begin failures++; $display("FAIL arb_commit[%0d] got=%0d/%h exp=%0d/%h", i, ifc.rf_addr, ifc.rf_data, m_addr, m_data); end
      if (mem_acc) ifc.mem_wb_data = $urandom;
    end
    ifc.alu_wb_valid = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL arb_drain_ready[%0d] got=%b exp=%b", i, obs_ready, exp_ready); end
      checks++; if (ifc.rf_we !== m_we || ifc.rf_addr !== m_addr)
        begin failures++; $display("FAIL arb_drain_commit[%0d] got=%b/%0d exp=%b/%0d", i, ifc.rf_we, ifc.rf_addr, m_we, m_addr); end
      if (mem_acc) ifc.mem_wb_data = $urandom;
    end
    settle();
  endtask

  task automatic test_reg0();
    ifc.mem_wb_valid = 1; ifc.mem_wb_addr = 0; ifc.mem_wb_data = 32'h1234_5678;
    step();
    ifc.mem_wb_valid = 0;
    checks++; if (obs_ready !== 1'b1) begin failures++; $display("FAIL r0_ready got=%b exp=1", obs_ready); end
    checks++; if (ifc.rf_we !== 1'b0) begin failures++; $display("FAIL r0_we got=%b exp=0", ifc.rf_we); end
    ifc.issue_valid = 1; ifc.issue_wr = 1; ifc.issue_dst = 0;
    step();
    ifc.issue_valid = 0; ifc.issue_wr = 0;
    checks++; if (obs_stall !== 1'b0) begin failures++; $display("FAIL r0_stall got=%b exp=0", obs_stall); end
    checks++; if (ifc.busy !== 32'd0) begin failures++; $display("FAIL r0_busy got=%h exp=0", ifc.busy); end
  endtask

  task automatic test_async_reset();
    ifc.issue_valid = 1; ifc.issue_wr = 1; ifc.issue_dst = 3;
    step();
    ifc.issue_dst = 8;
    step();
    idle_inputs();
    checks++; if (ifc.busy !== 32'h0000_0108) begin failures++; $display("FAIL ar_busy_pre got=%h exp=00000108", ifc.busy); end
    ifc.mem_wb_valid = 1; ifc.mem_wb_addr = 20; ifc.mem_wb_data = $urandom;
    for (int i = 0; i < 3; i++) begin
      ifc.alu_wb_valid = 1; ifc.alu_wb_addr = 5'(21 + i); ifc.alu_wb_data = $urandom;
      step();
      if (mem_acc) ifc.mem_wb_data = $urandom;
    end
    ifc.alu_wb_valid = 0;
    checks++; if (ifc.rf_we !== 1'b1) begin failures++; $display("FAIL ar_we_pre got=%b exp=1", ifc.rf_we); end
    #2 reset = 1'b1;
    #1;
    checks++; if (ifc.busy !== 32'd0) begin failures++; $display("FAIL ar_busy got=%h exp=0", ifc.busy); end
    checks++; if (ifc.rf_we !== 1'b0) begin failures++; $display("FAIL ar_we got=%b exp=0", ifc.rf_we); end
    checks++; if (ifc.issue_stall !== 1'b1) begin failures++; $display("FAIL ar_stall got=%b exp=1", ifc.issue_stall); end
    checks++; if (ifc.mem_wb_ready !== 1'b0) begin failures++; $display("FAIL ar_ready got=%b exp=0", ifc.mem_wb_ready); end
    model_reset();
    idle_inputs();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (ifc.rf_we !== 1'b0 || obs_ready !== 1'b0 || ifc.busy !== 32'd0)
        begin failures++; $display("FAIL ar_stale[%0d] got we=%b rdy=%b busy=%h exp=0/0/0", i, ifc.rf_we, obs_ready, ifc.busy); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      ifc.issue_valid = ($urandom_range(0, 1) == 1);
      ifc.issue_rs    = 5'($urandom_range(0, 7));
      ifc.issue_rt    = 5'($urandom_range(0, 7));
      ifc.issue_dst   = 5'($urandom_range(0, 7));
      ifc.issue_wr    = ($urandom_range(0, 3) != 0);
      ifc.alu_wb_valid = ($urandom_range(0, 2) != 0);
      ifc.alu_wb_addr  = 5'($urandom_range(0, 31));
      ifc.alu_wb_data  = $urandom;
      if (!ifc.mem_wb_valid || mem_acc) begin
        ifc.mem_wb_valid = ($urandom_range(0, 4) < 2);
        ifc.mem_wb_addr  = 5'($urandom_range(0, 31));
        ifc.mem_wb_data  = $urandom;
      end
      step();
      checks++; if (obs_stall !== exp_stall) begin failures++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", i, obs_stall, exp_stall); end
      checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, obs_ready, exp_ready); end
      checks++; if (ifc.busy !== m_busy) begin failures++; $display("FAIL rnd_busy[%0d] got=%h exp=%h", i, ifc.busy, m_busy); end
      checks++; if (ifc.rf_we !== m_we) begin failures++; $display("FAIL rnd_we[%0d] got=%b exp=%b", i, ifc.rf_we, m_we); end
      checks++; if (ifc.rf_addr !== m_addr || ifc.rf_data !== m_data)
        begin failures++; $display("FAIL rnd_commit[%0d] got=%0d/%h exp=%0d/%h", i, ifc.rf_addr, ifc.rf_data, m_addr, m_data); end
      checks++; if (ifc.overflow !== m_ovf) begin failures++; $display("FAIL rnd_ovf[%0d] got=%b exp=%b", i, ifc.overflow, m_ovf); end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_scoreboard();
    test_alu_latency();
    test_arbitration();
    test_reg0();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
